// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 20;
  localparam int unsigned DATA_W_DEFAULT = 16;

  // Requester identifiers
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sram_arb_watchdog.sv
// Counts cycles while enabled; flags expiry in the TIMEOUT-th enabled cycle.
module sram_arb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  logic [CNT_W-1:0] cnt;

  // Counter restarts from zero whenever the wait window is closed
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      cnt <= '0;
    end else if (!expired) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = enable && (cnt == CNT_W'(LAST));

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester arbiter in front of sram_ctrl: grants one requester,
// issues a single start pulse, waits for ready (bounded by a watchdog)
// and acks the grantee.
// Optional build macro: SRAM_ARB_ROUND_ROBIN_EN (alternating tie-break);
// default build gives requester A fixed priority.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W  = DATA_W_DEFAULT,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              rw_a,
  input  logic              rw_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic [DATA_W-1:0] rdata,
  output logic              sram_start_n,
  output logic              sram_rw,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic              sram_ready,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy,
  output logic              timeout_err
);

  state_t state;
  state_t state_next;
  logic   grant_id;

  logic   grant_c;
  logic   sel_c;
  logic   tie_winner_c;
  logic   capture_c;
  logic   abort_c;
  logic   wdog_expired;

  logic   start_n_next;
  logic   busy_next;
  logic   ack_a_next;
  logic   ack_b_next;

  // Bounds the time spent waiting for sram_ready
  sram_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .enable  (state == WAIT),
    .expired (wdog_expired)
  );

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic rr_ptr;

  // Pointer names the winner of the next tie; after each contested grant
  // it moves to the requester that lost, so ties alternate
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= REQ_A;
    end else if (grant_c && req_a && req_b) begin
      rr_ptr <= ~sel_c;
    end
  end

  assign tie_winner_c = rr_ptr;
`else
  assign tie_winner_c = REQ_A;
`endif

  // Requester selection and transaction event decode
  always_comb begin
    sel_c = REQ_A;
    if (req_a && req_b) begin
      sel_c = tie_winner_c;
    end else if (req_b) begin
      sel_c = REQ_B;
    end
    grant_c   = (state == IDLE) && (req_a || req_b);
    capture_c = (state == WAIT) && sram_ready && sram_rw;
    abort_c   = (state == WAIT) && !sram_ready && wdog_expired;
  end

  // Next state and next values of the registered status outputs
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_a || req_b) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT: begin
        if (sram_ready) begin
          state_next = DONE;
        end else if (wdog_expired) begin
          state_next = IDLE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    start_n_next = (state_next != ISSUE);
    busy_next    = (state_next != IDLE);
    ack_a_next   = (state_next == DONE) && (grant_id == REQ_A);
    ack_b_next   = (state_next == DONE) && (grant_id == REQ_B);
  end

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      grant_id     <= REQ_A;
      sram_start_n <= 1'b1;
      sram_rw      <= 1'b1;
      sram_addr    <= '0;
      sram_wdata   <= '0;
      ack_a        <= 1'b0;
      ack_b        <= 1'b0;
      rdata        <= '0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_next;
      sram_start_n <= start_n_next;
      busy         <= busy_next;
      ack_a        <= ack_a_next;
      ack_b        <= ack_b_next;
      if (grant_c) begin
        grant_id   <= sel_c;
        sram_rw    <= (sel_c == REQ_B) ? rw_b    : rw_a;
        sram_addr  <= (sel_c == REQ_B) ? addr_b  : addr_a;
        sram_wdata <= (sel_c == REQ_B) ? wdata_b : wdata_a;
      end
      if (capture_c) begin
        rdata <= sram_rdata;
      end
      if (abort_c) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter (TIMEOUT=8); expects alternating ties
// when built with SRAM_ARB_ROUND_ROBIN_EN.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic        rw_a = 1'b1, rw_b = 1'b1;
  logic [19:0] addr_a = '0, addr_b = '0;
  logic [15:0] wdata_a = '0, wdata_b = '0;
  logic        ack_a, ack_b;
  logic [15:0] rdata;
  logic        sram_start_n, sram_rw;
  logic [19:0] sram_addr;
  logic [15:0] sram_wdata;
  logic        sram_ready = 1'b0;
  logic [15:0] sram_rdata = '0;
  logic        busy, timeout_err;

  int checks = 0;
  int failures = 0;

  int   n_start, n_ack_a, n_ack_b, both_ever;
  logic order[$];

  int ready_delay = 2;
  bit never_ready = 1'b0;
  bit pend = 1'b0;
  int cd = 0;

  sram_arbiter #(
    .ADDR_W  (20),
    .DATA_W  (16),
    .TIMEOUT (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_a        (req_a),
    .req_b        (req_b),
    .rw_a         (rw_a),
    .rw_b         (rw_b),
    .addr_a       (addr_a),
    .addr_b       (addr_b),
    .wdata_a      (wdata_a),
    .wdata_b      (wdata_b),
    .ack_a        (ack_a),
    .ack_b        (ack_b),
    .rdata        (rdata),
    .sram_start_n (sram_start_n),
    .sram_rw      (sram_rw),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_ready   (sram_ready),
    .sram_rdata   (sram_rdata),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  // sram_ctrl stand-in: ready pulses ready_delay cycles after start_n low
  always @(negedge clk) begin
    sram_ready = 1'b0;
    if (!sram_start_n) begin
      pend = 1'b1;
      cd = ready_delay;
    end else if (pend) begin
      if (never_ready) begin
        pend = 1'b0;
      end else begin
        cd = cd - 1;
        if (cd <= 0) begin
          sram_ready = 1'b1;
          pend = 1'b0;
        end
      end
    end
  end

  // Requesters drop their request once they see their ack
  always @(negedge clk) begin
    if (ack_a) req_a = 1'b0;
    if (ack_b) req_b = 1'b0;
  end

  // Event monitor, sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    if (!sram_start_n) n_start++;
    if (ack_a) begin n_ack_a++; order.push_back(1'b0); end
    if (ack_b) begin n_ack_b++; order.push_back(1'b1); end
    if (ack_a && ack_b) both_ever++;
  end

  task automatic clr_mon();
    n_start = 0; n_ack_a = 0; n_ack_b = 0;
    order.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clr_mon();
  endtask

  task automatic wait_ack(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!(ack_a || ack_b) && cycles < budget);
  endtask

  task automatic wait_quiet(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (i > 0 && !req_a && !req_b && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_start(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!sram_start_n) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({sram_start_n, sram_rw, busy, timeout_err, ack_a, ack_b} !== 6'b110000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=110000", {sram_start_n, sram_rw, busy, timeout_err, ack_a, ack_b});
    end
    checks++;
    if ({sram_addr, sram_wdata, rdata} !== 52'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {sram_addr, sram_wdata, rdata});
    end
    reset = 1'b0;
    clr_mon();
  endtask

  task automatic test_single_read();
    int lat;
    do_reset();
    ready_delay = 2; never_ready = 1'b0; sram_rdata = 16'hBEEF;
    rw_a = 1'b1; addr_a = 20'h00010; req_a = 1'b1;
    wait_ack(20, lat);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL read_latency got=%0d exp=4", lat); end
    checks++;
    if ({ack_a, ack_b} !== 2'b10) begin failures++; $display("FAIL read_ack got=%b exp=10", {ack_a, ack_b}); end
    checks++;
    if (rdata !== 16'hBEEF) begin failures++; $display("FAIL read_rdata got=%h exp=beef", rdata); end
    sram_rdata = 16'h0000;
    repeat (3) @(negedge clk);
    checks++;
    if (rdata !== 16'hBEEF) begin failures++; $display("FAIL read_rdata_hold got=%h exp=beef", rdata); end
    checks++;
    if ({sram_addr, sram_rw} !== {20'h00010, 1'b1}) begin
      failures++; $display("FAIL read_cmd got=%h/%b exp=00010/1", sram_addr, sram_rw);
    end
    checks++;
    if (n_start !== 1) begin failures++; $display("FAIL read_start_pulses got=%0d exp=1", n_start); end
    checks++;
    if ({n_ack_a, n_ack_b} !== {32'd1, 32'd0}) begin
      failures++; $display("FAIL read_ack_counts got=%0d/%0d exp=1/0", n_ack_a, n_ack_b);
    end
  endtask

  task automatic test_priority();
    bit ok;
    do_reset();
    ready_delay = 1; never_ready = 1'b0;
    rw_a = 1'b1; addr_a = 20'h00100; rw_b = 1'b1; addr_b = 20'h00200;
    req_a = 1'b1; req_b = 1'b1;
    wait_quiet(60, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL prio_complete got=busy exp=idle"); end
    checks++;
    if (order.size() !== 2 || order[0] !== 1'b0 || order[1] !== 1'b1) begin
      failures++; $display("FAIL prio_order got_size=%0d exp=A,B", order.size());
    end
    checks++;
    if (n_start !== 2) begin failures++; $display("FAIL prio_start_pulses got=%0d exp=2", n_start); end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [3:0] got;
    logic [3:0] exp;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    exp = 4'b0110;
`else
    exp = 4'b0101;
`endif
    do_reset();
    ready_delay = 1; never_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      req_a = 1'b1; req_b = 1'b1;
      wait_quiet(60, ok);
    end
    got = 4'bxxxx;
    if (order.size() == 4) got = {order[0], order[1], order[2], order[3]};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL rr_order got=%b exp=%b (0=A 1=B)", got, exp); end
    checks++;
    if (n_start !== 4) begin failures++; $display("FAIL rr_start_pulses got=%0d exp=4", n_start); end
  endtask

  task automatic test_timeout();
    int k;
    int lat;
    do_reset();
    never_ready = 1'b1;
    rw_b = 1'b0; addr_b = 20'h00123; wdata_b = 16'hCAFE; req_b = 1'b1;
    wait_start(20);
    k = 0;
    while (!timeout_err && k < 30) begin
      @(negedge clk);
      k++;
    end
    req_b = 1'b0;
    checks++;
    if (k !== 9) begin failures++; $display("FAIL timeout_cycles got=%0d exp=9", k); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL timeout_busy got=%b exp=0", busy); end
    checks++;
    if ({sram_rw, sram_wdata, rdata} !== {1'b0, 16'hCAFE, 16'h0000}) begin
      failures++; $display("FAIL timeout_cmd got=%b/%h/%h exp=0/cafe/0000", sram_rw, sram_wdata, rdata);
    end
    repeat (4) @(negedge clk);
    checks++;
    if ({n_start, n_ack_a, n_ack_b} !== {32'd1, 32'd0, 32'd0}) begin
      failures++; $display("FAIL timeout_no_ack got=%0d/%0d/%0d exp=1/0/0", n_start, n_ack_a, n_ack_b);
    end
    never_ready = 1'b0; ready_delay = 1; sram_rdata = 16'h1234;
    rw_a = 1'b1; addr_a = 20'h00020; req_a = 1'b1;
    wait_ack(20, lat);
    checks++;
    if (lat !== 3 || ack_a !== 1'b1) begin
      failures++; $display("FAIL timeout_next_served got=lat%0d ack%b exp=lat3 ack1", lat, ack_a);
    end
    checks++;
    if (rdata !== 16'h1234) begin failures++; $display("FAIL timeout_next_rdata got=%h exp=1234", rdata); end
    checks++;
    if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%b exp=1", timeout_err); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    clr_mon();
    never_ready = 1'b1;
    rw_a = 1'b1; addr_a = 20'h00555; wdata_a = 16'h9999; req_a = 1'b1;
    wait_start(20);
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
    reset = 1'b1; req_a = 1'b0;
    @(negedge clk);
    checks++;
    if ({sram_start_n, sram_rw, busy, timeout_err} !== 4'b1100) begin
      failures++; $display("FAIL rstmid_ctrl got=%b exp=1100", {sram_start_n, sram_rw, busy, timeout_err});
    end
    checks++;
    if (sram_addr !== 20'h0) begin failures++; $display("FAIL rstmid_addr got=%h exp=0", sram_addr); end
    checks++;
    if (sram_wdata !== 16'h0) begin failures++; $display("FAIL rstmid_wdata got=%h exp=0", sram_wdata); end
    checks++;
    if (rdata !== 16'h0) begin failures++; $display("FAIL rstmid_rdata got=%h exp=0", rdata); end
    reset = 1'b0; never_ready = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if ({n_ack_a, n_ack_b} !== {32'd0, 32'd0} || busy !== 1'b0) begin
      failures++; $display("FAIL rstmid_no_ack got=%0d/%0d busy%b exp=0/0 busy0", n_ack_a, n_ack_b, busy);
    end
  endtask

  task automatic test_hold();
    int cyc;
    bit bad;
    do_reset();
    ready_delay = 2; never_ready = 1'b0; sram_rdata = 16'h7777;
    rw_a = 1'b0; addr_a = 20'h00ABC; wdata_a = 16'h5A5A; req_a = 1'b1;
    @(negedge clk);
    addr_a = 20'hFFFFF; wdata_a = 16'h0001; rw_a = 1'b1;
    bad = 1'b0; cyc = 0;
    while (!ack_a && cyc < 20) begin
      if (sram_addr !== 20'h00ABC) bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
    if (sram_addr !== 20'h00ABC) bad = 1'b1;
    checks++;
    if (bad) begin failures++; $display("FAIL hold_addr got=%h exp=00abc", sram_addr); end
    checks++;
    if (ack_a !== 1'b1) begin failures++; $display("FAIL hold_ack got=%b exp=1", ack_a); end
    checks++;
    if ({sram_rw, sram_wdata} !== {1'b0, 16'h5A5A}) begin
      failures++; $display("FAIL hold_cmd got=%b/%h exp=0/5a5a", sram_rw, sram_wdata);
    end
    checks++;
    if (rdata !== 16'h0000) begin failures++; $display("FAIL hold_write_rdata got=%h exp=0000", rdata); end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    both_ever = 0;
    clr_mon();
    @(negedge clk);
    test_reset();
    test_single_read();
    test_priority();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_hold();
    checks++;
    if (both_ever !== 0) begin failures++; $display("FAIL ack_exclusive got=%0d exp=0", both_ever); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, SRAM data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum cycles waiting for sram_ready before abort.
REQ-004 SHALL have port clk  in  1  single system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports req_a / req_b  in  1  level request from pixel writer (A) and pixel reader (B).
REQ-007 SHALL have ports rw_a / rw_b  in  1  1 = read, 0 = write.
REQ-008 SHALL have ports addr_a / addr_b  in  ADDR_W  request address.
REQ-009 SHALL have ports wdata_a / wdata_b  in  DATA_W  write data.
REQ-010 SHALL have ports ack_a / ack_b  out  1  one-cycle completion pulse to the grantee.
REQ-011 SHALL have port rdata  out  DATA_W  read data; valid in the ack cycle, held until the next ack.
REQ-012 SHALL have ports sram_start_n  out  1, sram_rw  out  1, sram_addr  out  ADDR_W, sram_wdata  out  DATA_W  command to sram_ctrl.
REQ-013 SHALL have ports sram_ready  in  1 and sram_rdata  in  DATA_W  completion and data from sram_ctrl.
REQ-014 SHALL have ports busy  out  1 (state != IDLE) and timeout_err  out  1 (sticky abort flag).

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
REQ-016 In IDLE, if any req is high, SHALL grant one requester and register its rw/addr/wdata into the sram_* outputs, then go to ISSUE.
REQ-017 Without a round-robin build, A SHALL have fixed priority over B when both request in the same cycle.
REQ-018 In ISSUE, SHALL drive sram_start_n=0 for exactly one cycle, then go to WAIT.
REQ-019 In WAIT, when sram_ready=1, SHALL capture sram_rdata into rdata (reads only) and go to DONE.
REQ-020 In DONE, SHALL pulse the grantee's ack for one cycle, then return to IDLE.
REQ-021 Minimum request-to-ack latency SHALL be 3 cycles plus sram_ctrl latency.
REQ-022 Requesters SHALL hold req until they see ack; req still high in the cycle after ack counts as a new request.
REQ-023 Changes to a grantee's inputs after the grant cycle SHALL be ignored.
REQ-024 In WAIT, a counter SHALL run from 0; at TIMEOUT it SHALL abort, set timeout_err, and go to IDLE without acking.
REQ-025 timeout_err SHALL clear only on reset.
REQ-026 sram_ready outside WAIT SHALL be ignored.
REQ-027 ack_a and ack_b SHALL never be high in the same cycle.

Reset
REQ-028 When reset is high at a clk edge, SHALL set state=IDLE; sram_start_n=1; sram_rw=1; sram_addr=0; sram_wdata=0; ack_a=ack_b=0; rdata=0; busy=0; timeout_err=0; RR pointer=A.
REQ-029 Reset mid-transaction SHALL abandon the transaction with no ack.

Configuration
REQ-030 With macro SRAM_ARB_ROUND_ROBIN_EN defined, SHALL keep a last-granted pointer; on simultaneous requests the non-last requester wins; the pointer updates at grant.
REQ-031 Without SRAM_ARB_ROUND_ROBIN_EN, SHALL use fixed A priority and SHALL implement no pointer register.

Structure
REQ-032 Package sram_arb_pkg SHALL hold the state enum (IDLE, ISSUE, WAIT, DONE), the requester-ID constants (A=0, B=1) and the default ADDR_W/DATA_W values.
REQ-033 The TIMEOUT counter SHALL be the single sub-module sram_arb_watchdog (inputs: clk, reset, enable; output: expired).

Verification
REQ-034 Bench SHALL cover: req_a, read, addr 0x00010; sram_ready 2 cycles after start_n low, sram_rdata 0xBEEF -> one start_n pulse, ack_a with rdata=0xBEEF, no ack_b.
REQ-035 Bench SHALL cover: req_a and req_b asserted in the same cycle, default build -> A served first, then B; exactly 2 start_n pulses.
REQ-036 Bench SHALL cover: same stimulus as REQ-035 with SRAM_ARB_ROUND_ROBIN_EN, repeated twice -> grant order A, B, B, A.
REQ-037 Bench SHALL cover: req_b write, sram_ready never asserted, TIMEOUT=8 -> abort after 8 WAIT cycles; timeout_err=1; no ack; next request still served.
REQ-038 Bench SHALL cover: reset asserted during WAIT -> next cycle all outputs at reset values, no ack.
REQ-039 Bench SHALL cover: addr_a changed in the cycle after grant -> sram_addr keeps the original value until ack.
